psa_ram_reader: RTL and testbench

Z80-side read-back engine for the PSA sample/pattern SRAM: the reverse path of the existing register-driven RAM write port. The host loads an 11-bit SRAM address through I/O registers and issues a fetch command. The block then arbitrates for the shared CA/CD bus, runs a timed SRAM read cycle, latches the byte and presents it on a host I/O read register. It sits beside the write-port decoder and shares the o_CA/o_nRAM_CS lines through the board-level arbiter.

---
 rtl/psa_ram_reader.sv | 88 ++++++++
 tb/tb_psa_ram_reader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/psa_ram_reader.sv
// psa_ram_reader: host-driven SRAM read-back engine (optional PSA_RDBACK_AUTOINC_EN enables read-triggered auto-increment fetch)
module psa_ram_reader #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [7:0]  BASE_ADDR     = 8'h08
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_nIORQ,
  input  logic        i_nRD,
  input  logic        i_nWR,
  input  logic [7:0]  i_ZA,
  input  logic [7:0]  i_ZD,
  output logic [7:0]  o_ZD,
  output logic        o_ZD_OE,
  output logic        o_REQ,
  input  logic        i_GRANT,
  output logic [10:0] o_CA,
  input  logic [7:0]  i_CD,
  output logic        o_nRAM_CS,
  output logic        o_nRAM_OE,
  output logic        o_BUSY
);
  typedef enum logic [1:0] {IDLE, REQ, SETUP, STROBE} state_t;
  state_t state, state_n;
  logic [10:0] addr, ca;
  logic [7:0] data;
  logic [3:0] cnt;
  logic done, wr_q, rd_q;
  logic wr_now, rd_now, wr_ev, rd_ev, hit, busy, data_rd, inc, start, last;
  logic unused;
  assign unused = ^i_ZD[6:3];
  assign wr_now = !i_nIORQ && !i_nWR;
  assign rd_now = !i_nIORQ && !i_nRD;
  assign wr_ev = wr_now && !wr_q;
  assign rd_ev = rd_now && !rd_q;
  assign hit = i_ZA[7:2] == BASE_ADDR[7:2];
  assign busy = state != IDLE;
  assign data_rd = rd_ev && hit && i_ZA[1:0] == 2'd2;
`ifdef PSA_RDBACK_AUTOINC_EN
  assign inc = data_rd && !busy;
`else
  assign inc = 1'b0;
`endif
  assign start = !busy && ((wr_ev && hit && i_ZA[1:0] == 2'd1 && i_ZD[7]) || inc);
  assign last = state == STROBE && cnt == 4'(ACCESS_CYCLES - 1);
  assign o_BUSY = busy;
  assign o_REQ = busy;
  assign o_nRAM_CS = !(state == SETUP || state == STROBE);
  assign o_nRAM_OE = state != STROBE;
  assign o_CA = ca;
  assign o_ZD_OE = rd_now && hit;
  assign o_ZD = !o_ZD_OE ? 8'h00 : i_ZA[1:0] == 2'd2 ? data : i_ZA[1:0] == 2'd3 ? {6'b0, done, busy} : 8'h00;
  // state register
  always_ff @(posedge i_CLK) begin
    if (i_RST) state <= IDLE;
    else state <= state_n;
  end
  // next-state: wait for grant, one setup cycle, then the timed strobe
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? REQ : IDLE) :
              state == REQ ? (i_GRANT ? SETUP : REQ) :
              state == SETUP ? STROBE : (last ? IDLE : STROBE);
  end
  // host registers, strobe history, bus address and data capture
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      addr <= '0;
      ca <= '0;
      data <= '0;
      cnt <= '0;
      done <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= wr_now;
      rd_q <= rd_now;
      if (wr_ev && hit && !busy && i_ZA[1:0] == 2'd0) addr[7:0] <= i_ZD;
      else if (wr_ev && hit && !busy && i_ZA[1:0] == 2'd1) addr[10:8] <= i_ZD[2:0];
      else if (inc) addr <= addr + 11'd1;
      if (state == REQ && i_GRANT) ca <= addr;
      cnt <= state == SETUP ? 4'd0 : cnt + 4'd1;
      if (last) data <= i_CD;
      if (last) done <= 1'b1;
      else if (data_rd && !busy) done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_psa_ram_reader.sv
// tb_psa_ram_reader: scoreboard bench for psa_ram_reader against an SRAM array model
module tb_psa_ram_reader;
  localparam logic [7:0] B = 8'h08;
  localparam int AC = 2;
  logic clk = 0, rst = 1, n_iorq = 1, n_rd = 1, n_wr = 1, grant = 1;
  logic [7:0] za = 0, zd_in = 0, zd_out, cd;
  logic zd_oe, req, nram_cs, nram_oe, busy;
  logic [10:0] ca;
  logic [7:0] mem [2048];
  logic [8:0] sb [$];
  int n_tests = 0, n_fail = 0, cs_falls = 0;
  logic cs_q = 1, act_q = 0;
  logic [10:0] ca_seen = 0;
  logic [7:0] last_data = 0;

  psa_ram_reader #(.ACCESS_CYCLES(AC), .BASE_ADDR(B)) dut (
    .i_CLK(clk), .i_RST(rst), .i_nIORQ(n_iorq), .i_nRD(n_rd), .i_nWR(n_wr),
    .i_ZA(za), .i_ZD(zd_in), .o_ZD(zd_out), .o_ZD_OE(zd_oe), .o_REQ(req),
    .i_GRANT(grant), .o_CA(ca), .i_CD(cd), .o_nRAM_CS(nram_cs),
    .o_nRAM_OE(nram_oe), .o_BUSY(busy)
  );

  assign cd = mem[ca];
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic a;
    logic [8:0] e;
    a = !n_iorq && !n_rd;
    if (a && !act_q) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: unexpected host read of %0h", za);
      end else begin
        e = sb.pop_front();
        chk("host_read", {zd_oe, zd_out}, e);
      end
    end
    act_q = a;
    if (cs_q && !nram_cs) begin
      cs_falls++;
      ca_seen = ca;
    end
    cs_q = nram_cs;
  end

  task automatic hwrite(input logic [1:0] off, input logic [7:0] v);
    @(posedge clk); #1 za = {B[7:2], off}; zd_in = v; n_iorq = 0; n_wr = 0;
    @(posedge clk); #1 n_iorq = 1; n_wr = 1;
  endtask

  task automatic hread(input logic [7:0] a, input logic [8:0] e);
    @(posedge clk); #1 sb.push_back(e); za = a; n_iorq = 0; n_rd = 0;
    @(posedge clk); #1 n_iorq = 1; n_rd = 1;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic fetch_timed(input logic [10:0] a, input int g);
    logic ecs, eoe;
    grant = (g == 0);
    hwrite(2'd0, a[7:0]);
    hwrite(2'd1, {5'b10000, a[10:8]});
    for (int k = 0; k <= g + AC + 2; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == g) grant = 1;
      @(negedge clk);
      ecs = !(k >= g + 1 && k <= g + 1 + AC);
      eoe = !(k >= g + 2 && k <= g + 1 + AC);
      chk("cs_n", nram_cs, ecs);
      chk("oe_n", nram_oe, eoe);
      chk("busy", busy, k < g + 2 + AC);
      if (k < g + 2) chk("req_hi", req, 1);
      if (k >= g + 2 + AC) chk("req_lo", req, 0);
      if (!ecs) chk("ca", ca, a);
    end
  endtask

  task automatic post_data(input logic [10:0] a);
    logic [10:0] n;
    n = a + 11'd1;
    hread({B[7:2], 2'd3}, {1'b1, 8'h02});
    hread({B[7:2], 2'd2}, {1'b1, mem[a]});
    last_data = mem[a];
`ifdef PSA_RDBACK_AUTOINC_EN
    wait_idle("autoinc_idle");
    last_data = mem[n];
    chk("autoinc_ca", ca, n);
    hread({B[7:2], 2'd3}, {1'b1, 8'h02});
`else
    hread({B[7:2], 2'd3}, {1'b1, 8'h00});
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [10:0] a;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[11'h7AD] = 8'hCD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_cs", nram_cs, 1);
    chk("rst_oe", nram_oe, 1);
    chk("rst_ca", ca, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 0;
    hread({B[7:2], 2'd2}, {1'b1, 8'h00});
    hread({B[7:2], 2'd3}, {1'b1, 8'h00});
    fetch_timed(11'h7AD, 0);
    post_data(11'h7AD);
    fetch_timed(11'h123, 5);
    post_data(11'h123);
    n0 = cs_falls;
    grant = 0;
    hwrite(2'd0, 8'hAD);
    hwrite(2'd1, 8'h87);
    hwrite(2'd0, 8'h55);
    hwrite(2'd1, 8'h83);
    hread({B[7:2], 2'd2}, {1'b1, last_data});
    chk("busy_in_req", busy, 1);
    chk("cs_in_req", nram_cs, 1);
    grant = 1;
    wait_idle("busy_ignore_idle");
    chk("one_sram_cycle", cs_falls - n0, 1);
    chk("addr_kept", ca_seen, 11'h7AD);
    post_data(11'h7AD);
    hwrite(2'd0, 8'h40);
    hwrite(2'd1, 8'h82);
    @(posedge clk); #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_cs", nram_cs, 1);
    chk("midrst_oe", nram_oe, 1);
    chk("midrst_req", req, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1 rst = 0;
    last_data = 0;
    hread({B[7:2], 2'd2}, {1'b1, 8'h00});
    hread({B[7:2], 2'd3}, {1'b1, 8'h00});
    @(posedge clk); #1 rst = 1; za = {B[7:2], 2'd1}; zd_in = 8'h85; n_iorq = 0; n_wr = 0;
    @(posedge clk); #1 rst = 0; n_iorq = 1; n_wr = 1;
    @(negedge clk);
    chk("rst_wins_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wins_cs", nram_cs, 1);
    hread(8'h0C, {1'b0, 8'h00});
    hread(8'h07, {1'b0, 8'h00});
    chk("outside_busy", busy, 0);
    hread({B[7:2], 2'd3}, {1'b1, 8'h00});
    for (int i = 0; i < 12; i++) begin
      a = 11'($urandom);
      fetch_timed(a, int'($urandom_range(0, 4)));
      post_data(a);
    end
`ifdef PSA_RDBACK_AUTOINC_EN
    mem[11'h7FF] = 8'h11;
    mem[11'h000] = 8'h22;
    fetch_timed(11'h7FF, 0);
    hread({B[7:2], 2'd2}, {1'b1, 8'h11});
    wait_idle("wrap_idle");
    chk("wrap_ca", ca, 11'h000);
    hread({B[7:2], 2'd2}, {1'b1, 8'h22});
    wait_idle("wrap_idle2");
    chk("wrap_ca2", ca, 11'h001);
`endif
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
